ti_sbox_lut_pipe: RTL and testbench
===================================

Name: ti_sbox_lut_pipe

Overview:
- Parametrised, pipelined threshold-implementation (TI) S-box evaluator.
- The S-box is decomposed into R quadratic stages. Each stage holds SH×NB component functions; each component function is a run-time loadable truth table.
- A register bank sits between stages, giving glitch isolation as TI requires.
- It replaces the family of fixed per-bit combinational component LUTs with one reusable block, for use in masked round datapaths.

Parameters:
- NB, 4, S-box width in bits per share.
- SH, 3, number of shares (≥3). Each component function reads SH-1 shares (non-completeness).
- R, 2, number of decomposition stages, equal to the pipeline depth.
- Derived constants, not overridable:
  - IW = (SH-1)*NB, the component input width.
  - RW = max(1, clog2(R)).
  - SW = clog2(SH).
  - BW = max(1, clog2(NB)).
  - CW = RW+SW+BW+IW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input shares present.
- in_ready  out  1  input accepted this cycle when in_valid & in_ready.
- in_shares  in  SH*NB  share k occupies bits [k*NB +: NB].
- out_valid  out  1  output shares present.
- out_ready  in  1  downstream accepts.
- out_shares  out  SH*NB  same packing as in_shares.
- cfg_we  in  1  truth-table bit write strobe.
- cfg_addr  in  CW  {stage, share, bit, entry}, with stage in the MSBs and entry in the IW LSBs.
- cfg_wdata  in  1  table bit value.
- cfg_ready  out  1  pipeline empty; writes are legal.
- cfg_err  out  1  sticky flag: a write was dropped.

Behaviour:
- Table storage:
  - There are R*SH*NB tables, each 2^IW × 1 bit.
  - Contents are not affected by rst and are undefined at power-up. The integrator must load every table before first use.
- Component evaluation, stage s, output share i, bit b:
  - idx = {x[(i+SH-1)%SH], …, x[(i+2)%SH], x[(i+1)%SH]}, with share (i+1)%SH in the LSBs.
  - The output is T[s][i][b][idx].
  - Output share i never depends on input share i.
- Stage s input:
  - Stage 0 reads in_shares.
  - Stage s>0 reads the stage s-1 register.
  - Every stage output is registered.
- Pipeline control:
  - There is one pipeline-wide enable: adv = (out_ready | ~out_valid) & ~cfg_we.
  - When adv is high, all stage registers and their valid bits shift by one. Stage 0 valid loads in_valid.
  - When adv is low, all registers hold.
  - in_ready = adv.
- Latency and throughput:
  - Latency is exactly R cycles from the accept edge to out_valid, given no stall.
  - Throughput is 1 per cycle.
  - Bubbles are not collapsed.
- out_shares is the final-stage register. When out_valid=0 its value is don't-care.
- Occupancy counter:
  - Width clog2(R+1).
  - Incremented on accept (in_valid & in_ready).
  - Decremented on output transfer (out_valid & out_ready).
  - Simultaneous accept and transfer leaves it unchanged.
  - cfg_ready = (count == 0) & ~in_valid.
- Configuration writes:
  - A write happens on cfg_we & cfg_ready.
  - cfg_we with cfg_ready=0 is dropped, no table changes, and cfg_err is set. cfg_err holds until rst.
  - cfg_we forces in_ready=0 in the same cycle, so a write and an accept are never simultaneous.
- Address decode:
  - An out-of-range stage, share or bit field is dropped and sets cfg_err.
  - Entry is always in range.
- Reset:
  - Resets count, all valid bits, out_valid and cfg_err to 0. Data registers reset to 0.
  - A reset mid-operation discards all in-flight items. No output is produced for them.
  - After rst deasserts, cfg_ready=1 as soon as in_valid=0.
- Power: data registers load only on adv, to avoid extra share toggles.

Test Plan:
1. Rotate config and latency.
   - Load every table so that T[s][i][b][e] = e[b]; each stage then maps out share i = in share i+1.
   - Apply in_shares=0xA53 (share2=0xA, share1=0x5, share0=0x3), out_ready=1.
   - Required: out_valid rises exactly 2 cycles after accept, with out_shares=0x53A.
2. Streaming throughput.
   - Using the test 1 config, drive 8 back-to-back inputs 0x000..0x007 with out_ready=1.
   - Required: 8 consecutive out_valid cycles with rotated values, and in_ready constantly 1.
3. Backpressure.
   - Hold out_ready=0 for 3 cycles while out_valid=1.
   - Required: out_shares is stable, in_ready=0, and no item is lost or duplicated; the order is preserved after release.
4. Config while busy.
   - Pulse cfg_we while count=1.
   - Required: the table is unchanged (the next output still matches test 1 values), cfg_err=1, and cfg_err stays 1 until rst.
5. Non-completeness.
   - Load T[0][0][0][e]=1 for e=0x00 only, leaving the remaining tables as in test 1.
   - Toggle only input share 0.
   - Required: stage-0 output share 0 bit 0 is unchanged.
6. Reset mid-flight.
   - Accept 2 items, then assert rst for 1 cycle.
   - Required: out_valid=0, count=0, cfg_err=0 next cycle, and no output for the discarded items. Table contents are retained, so a new input gives the test 1 result.

Source files
------------

// File: rtl/ti_sbox_lut_pipe.sv
// ti_sbox_lut_pipe
// Pipelined threshold-implementation S-box evaluator. The S-box is split into
// R quadratic stages; every stage computes SH*NB component functions, each a
// run-time loadable 2^IW x 1 truth table. Each stage output is registered so
// that glitches cannot propagate across stages.
//
// Ports
//   clk, rst    rising-edge clock, synchronous active-high reset
//   in_valid    input shares present
//   in_ready    input accepted when in_valid & in_ready
//   in_shares   SH shares of NB bits, share k at [k*NB +: NB]
//   out_valid   output shares present
//   out_ready   downstream accepts
//   out_shares  final-stage register, same packing as in_shares
//   cfg_we      truth-table bit write strobe
//   cfg_addr    {stage, share, bit, entry}, entry in the IW LSBs
//   cfg_wdata   table bit value
//   cfg_ready   pipeline empty and no input pending; writes are legal
//   cfg_err     sticky: a write was dropped (busy or out-of-range address)
module ti_sbox_lut_pipe #(
  parameter int NB = 4,
  parameter int SH = 3,
  parameter int R  = 2,
  localparam int IW = (SH - 1) * NB,
  localparam int RW = (R > 1) ? $clog2(R) : 1,
  localparam int SW = $clog2(SH),
  localparam int BW = (NB > 1) ? $clog2(NB) : 1,
  localparam int CW = RW + SW + BW + IW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SH*NB-1:0] in_shares,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SH*NB-1:0] out_shares,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_addr,
  input  logic             cfg_wdata,
  output logic             cfg_ready,
  output logic             cfg_err
);

  localparam int DW   = SH * NB;
  localparam int NT   = R * SH * NB;
  localparam int NE   = 2 ** IW;
  localparam int TW   = (NT > 1) ? $clog2(NT) : 1;
  localparam int CNTW = $clog2(R + 1);

  // Truth tables: one NE-bit vector per (stage, share, bit); never reset.
  logic [NE-1:0] tbl [NT];

  logic [DW-1:0]   st_data [R];
  logic [DW-1:0]   st_in   [R];
  logic [DW-1:0]   st_out  [R];
  logic [R-1:0]    st_valid;
  logic [CNTW-1:0] count;

  logic adv;
  logic accept;
  logic xfer;

  logic [RW-1:0] a_stage;
  logic [SW-1:0] a_share;
  logic [BW-1:0] a_bit;
  logic [IW-1:0] a_entry;
  logic          addr_ok;
  logic          cfg_wr;
  logic [TW-1:0] wr_idx;

  assign {a_stage, a_share, a_bit, a_entry} = cfg_addr;

  assign addr_ok = (int'(a_stage) < R) && (int'(a_share) < SH) && (int'(a_bit) < NB);
  assign wr_idx  = TW'((int'(a_stage) * SH + int'(a_share)) * NB + int'(a_bit));
  assign cfg_wr  = cfg_we & cfg_ready & addr_ok;

  // A config strobe freezes the whole pipeline, so writes never race an accept.
  assign adv       = (out_ready | ~out_valid) & ~cfg_we;
  assign in_ready  = adv;
  assign out_valid = st_valid[R-1];
  assign out_shares = st_data[R-1];
  assign accept    = in_valid & in_ready;
  // Counted only when the final register actually advances; identical to
  // out_valid & out_ready whenever no config strobe is freezing the pipe.
  assign xfer      = out_valid & adv;
  assign cfg_ready = (count == '0) & ~in_valid;

  always_comb begin
    st_in[0] = in_shares;
    for (int unsigned s = 1; s < R; s++) begin
      st_in[s] = st_data[s-1];
    end
  end

  // Output share i is addressed by shares i+1 .. i+SH-1 (never share i),
  // with share (i+1)%SH in the LSBs of the table index.
  always_comb begin
    logic [IW-1:0] idx;
    idx = '0;
    for (int unsigned s = 0; s < R; s++) begin
      st_out[s] = '0;
      for (int unsigned i = 0; i < SH; i++) begin
        for (int unsigned j = 0; j < SH - 1; j++) begin
          idx[j*NB +: NB] = st_in[s][((i + 1 + j) % SH)*NB +: NB];
        end
        for (int unsigned b = 0; b < NB; b++) begin
          st_out[s][i*NB + b] = tbl[TW'((s * SH + i) * NB + b)][idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      tbl[wr_idx][a_entry] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      count    <= '0;
      cfg_err  <= 1'b0;
      for (int unsigned s = 0; s < R; s++) begin
        st_data[s] <= '0;
      end
    end else begin
      if (adv) begin
        st_valid[0] <= in_valid;
        for (int unsigned s = 1; s < R; s++) begin
          st_valid[s] <= st_valid[s-1];
        end
        for (int unsigned s = 0; s < R; s++) begin
          st_data[s] <= st_out[s];
        end
      end
      case ({accept, xfer})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (cfg_we && !(cfg_ready && addr_ok)) begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ti_sbox_lut_pipe.sv
// Bench for ti_sbox_lut_pipe (NB=4, SH=3, R=2). A monitor logs accepted inputs
// and delivered outputs; each test task compares deliveries against a
// truth-table model evaluated straight from the component-function rule.
module tb_ti_sbox_lut_pipe;
  localparam int NB = 4;
  localparam int SH = 3;
  localparam int R  = 2;
  localparam int IW = (SH - 1) * NB;
  localparam int NE = 2 ** IW;
  localparam int CW = 1 + 2 + 2 + IW;
  localparam int DW = SH * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_shares = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_shares;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_addr = '0;
  logic          cfg_wdata = 1'b0;
  logic          cfg_ready;
  logic          cfg_err;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  bit mt [R][SH][NB][NE];
  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] got_q[$];
  int unsigned   got_cyc[$];

  ti_sbox_lut_pipe #(.NB(NB), .SH(SH), .R(R)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
    .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Handshakes seen at the falling edge complete at the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_q.push_back(in_shares);
      if (out_valid && out_ready && !cfg_we) begin
        got_q.push_back(out_shares);
        got_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [NB-1:0] sh(logic [DW-1:0] x, int k);
    return x[k*NB +: NB];
  endfunction

  function automatic logic [DW-1:0] model_stage(int s, logic [DW-1:0] x);
    logic [DW-1:0] y;
    int e;
    y = '0;
    for (int i = 0; i < SH; i++) begin
      e = 0;
      for (int j = SH - 1; j >= 1; j--) e = e * (2 ** NB) + int'(sh(x, (i + j) % SH));
      for (int b = 0; b < NB; b++) y[i*NB + b] = mt[s][i][b][e];
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] model_pipe(logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = x;
    for (int s = 0; s < R; s++) y = model_stage(s, y);
    return y;
  endfunction

  // Two identity-rotation stages: out share i = in share (i+2)%3.
  function automatic logic [DW-1:0] rot2(logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < SH; i++) r[i*NB +: NB] = sh(v, (i + 2) % SH);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    acc_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic cfg_raw(int s, int i, int b, int e, bit v);
    cfg_we    = 1'b1;
    cfg_addr  = CW'(((s * 4 + i) * 4 + b) * NE + e);
    cfg_wdata = v;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write(int s, int i, int b, int e, bit v);
    cfg_raw(s, i, b, e, v);
    mt[s][i][b][e] = v;
  endtask

  task automatic load_rotate();
    for (int s = 0; s < R; s++)
      for (int i = 0; i < SH; i++)
        for (int b = 0; b < NB; b++)
          for (int e = 0; e < NE; e++)
            cfg_write(s, i, b, e, bit'((e >> b) & 1));
  endtask

  task automatic send(logic [DW-1:0] v);
    int n;
    in_valid  = 1'b1;
    in_shares = v;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (got_q.size() < acc_q.size() && n < 100) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_shares !== '0) begin errors++; $display("FAIL reset_out_shares: got %h want 000", out_shares); end
    clear_q();
    load_rotate();
    #1;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL load_cfg_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_rotate_latency();
    int n;
    clear_q();
    out_ready = 1'b1;
    in_valid = 1'b1; in_shares = 12'hA53;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL latency: got %0d cycles want 2", n); end
    checks++; if (out_shares !== 12'h53A) begin errors++; $display("FAIL lat_out_shares: got %h want 53a", out_shares); end
    wait_drain();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL lat_count: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_streaming();
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_shares = DW'(k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready); end
      step();
    end
    in_valid = 1'b0;
    wait_drain();
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", got_q.size()); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== rot2(DW'(k))) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, got_q[k], rot2(DW'(k))); end
      checks++; if (got_cyc[k] != got_cyc[0] + k) begin errors++; $display("FAIL stream_gap[%0d]: got cycle %0d want %0d", k, got_cyc[k], got_cyc[0] + k); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] it [3];
    clear_q();
    for (int k = 0; k < 3; k++) it[k] = DW'($urandom);
    out_ready = 1'b0;
    send(it[0]);
    send(it[1]);
    in_valid = 1'b1; in_shares = it[2];
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_shares !== model_pipe(it[0])) begin errors++; $display("FAIL bp_stable[%0d]: got %h want %h", k, out_shares, model_pipe(it[0])); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    wait_drain();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== model_pipe(it[k])) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, got_q[k], model_pipe(it[k])); end
    end
  endtask

  task automatic test_cfg_busy();
    logic [DW-1:0] x;
    int e;
    clear_q();
    out_ready = 1'b1;
    x = DW'($urandom);
    e = int'(sh(x, 2)) * 16 + int'(sh(x, 1));
    in_valid = 1'b1; in_shares = x;
    #1;
    step();
    in_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = CW'(e);
    cfg_wdata = ~mt[0][0][0][e];
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL busy_cfg_ready: got %b want 0", cfg_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %b want 0", in_ready); end
    step();
    cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL busy_cfg_err: got %b want 1", cfg_err); end
    wait_drain();
    send(x);
    wait_drain();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL busy_count: got %0d want 2", got_q.size()); end
    for (int k = 0; k < 2 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== model_pipe(x)) begin errors++; $display("FAIL busy_table[%0d]: got %h want %h", k, got_q[k], model_pipe(x)); end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL busy_sticky[%0d]: got %b want 1", k, cfg_err); end
    end
  endtask

  task automatic test_reset_midflight();
    clear_q();
    out_ready = 1'b1;
    send(DW'($urandom));
    send(DW'($urandom));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL mid_cfg_err: got %b want 0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_cfg_ready: got %b want 1", cfg_ready); end
    checks++; if (out_shares !== '0) begin errors++; $display("FAIL mid_out_shares: got %h want 000", out_shares); end
    clear_q();
    for (int k = 0; k < 5; k++) step();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_ghost: got %0d outputs want 0", got_q.size()); end
    send(12'hA53);
    wait_drain();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 12'h53A) begin errors++; $display("FAIL mid_retained: got %h want 53a", got_q[0]); end
    end
  endtask

  task automatic test_cfg_range();
    logic [DW-1:0] x, y;
    int e;
    clear_q();
    x = DW'($urandom);
    y = model_stage(0, x);
    e = int'(sh(y, 2)) * 16 + int'(sh(y, 1));
    // Share field 3 does not exist; an unchecked decode would land on stage 1 share 0.
    cfg_we = 1'b1;
    cfg_addr = CW'(((0 * 4 + 3) * 4 + 0) * NE + e);
    cfg_wdata = ~mt[1][0][0][e];
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL range_cfg_ready: got %b want 1", cfg_ready); end
    step();
    cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL range_cfg_err: got %b want 1", cfg_err); end
    send(x);
    wait_drain();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL range_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== model_pipe(x)) begin errors++; $display("FAIL range_table: got %h want %h", got_q[0], model_pipe(x)); end
    end
  endtask

  task automatic test_noncompleteness();
    logic [NB-1:0] x0a, x0b, x1, x2;
    bit want;
    for (int e = 0; e < NE; e++) cfg_write(0, 0, 0, e, bit'(e == 0));
    for (int t = 0; t < 6; t++) begin
      clear_q();
      x1  = ($urandom % 2 == 0) ? '0 : NB'($urandom);
      x2  = ($urandom % 2 == 0) ? '0 : NB'($urandom);
      x0a = NB'($urandom);
      x0b = x0a ^ NB'(1 + $urandom % 15);
      want = (x1 == 0) && (x2 == 0);
      out_ready = 1'b1;
      send({x2, x1, x0a});
      send({x2, x1, x0b});
      wait_drain();
      checks++; if (got_q.size() != 2) begin errors++; $display("FAIL nc_count[%0d]: got %0d want 2", t, got_q.size()); end
      if (got_q.size() == 2) begin
        checks++; if (got_q[0][8] !== want) begin errors++; $display("FAIL nc_bit_a[%0d]: got %b want %b", t, got_q[0][8], want); end
        checks++; if (got_q[1][8] !== got_q[0][8]) begin errors++; $display("FAIL nc_toggle[%0d]: got %b want %b", t, got_q[1][8], got_q[0][8]); end
        checks++; if (got_q[1] !== model_pipe({x2, x1, x0b})) begin errors++; $display("FAIL nc_full[%0d]: got %h want %h", t, got_q[1], model_pipe({x2, x1, x0b})); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate_latency();
    test_streaming();
    test_backpressure();
    test_cfg_busy();
    test_reset_midflight();
    test_cfg_range();
    test_noncompleteness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
